// File: rtl/channel_spatial_sequencer.sv
// -----------------------------------------------------------------------------
// channel_spatial_sequencer
//
// Purpose:
//   Single-stage pass-through register that tags every accepted beat with its
//   position inside a frame of NUM_CHANNELS x NUM_SPATIAL_BLOCKS beats. The
//   frame order is either spatial-inner (ORDER=0) or channel-inner (ORDER=1).
//   Each beat also gets its channel group and first/last-of-frame markers.
//
// Parameters:
//   NUM_CHANNELS        channels per frame (>=1)
//   NUM_SPATIAL_BLOCKS  spatial blocks per channel (>=1)
//   NUM_GROUPS          channel groups, divides NUM_CHANNELS (>=1)
//   ORDER               0 = spatial-inner, 1 = channel-inner
//   DATA_WIDTH          payload width
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   clear            synchronous restart of frame position (pipeline kept)
//   in_valid/in_ready   input handshake, in_data payload
//   out_valid/out_ready output handshake, out_data registered payload
//   out_channel/out_spatial/out_group  position tags of out_data
//   out_frame_first/out_frame_last     beat is first/last of its frame
//   frame_count      (optional) number of completed frames, 16-bit wrapping
//
// Optional feature:
//   Define CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN to add the frame_count
//   output and its counter. Without the macro the port and logic are absent.
// -----------------------------------------------------------------------------
module channel_spatial_sequencer #(
    parameter int NUM_CHANNELS       = 4,
    parameter int NUM_SPATIAL_BLOCKS = 4,
    parameter int NUM_GROUPS         = 2,
    parameter int ORDER              = 0,
    parameter int DATA_WIDTH         = 32,
    localparam int CW = (NUM_CHANNELS       > 1) ? $clog2(NUM_CHANNELS)       : 1,
    localparam int SW = (NUM_SPATIAL_BLOCKS > 1) ? $clog2(NUM_SPATIAL_BLOCKS) : 1,
    localparam int GW = (NUM_GROUPS         > 1) ? $clog2(NUM_GROUPS)         : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         out_channel,
    output logic [SW-1:0]         out_spatial,
    output logic [GW-1:0]         out_group,
    output logic                  out_frame_first,
    output logic                  out_frame_last
`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    // Channels per group; the group tag is the channel tag divided by this.
    localparam int CPG = NUM_CHANNELS / NUM_GROUPS;

    localparam logic [CW-1:0] CHAN_MAX = CW'(NUM_CHANNELS - 1);
    localparam logic [SW-1:0] SP_MAX   = SW'(NUM_SPATIAL_BLOCKS - 1);

    // Map a channel index onto its group index.
    function automatic logic [GW-1:0] group_of(input logic [CW-1:0] chan);
        return GW'(int'(chan) / CPG);
    endfunction

    logic [CW-1:0] chan_cnt_r;
    logic [SW-1:0] sp_cnt_r;
    logic [CW-1:0] chan_nxt_s;
    logic [SW-1:0] sp_nxt_s;
    logic          chan_at_max_s;
    logic          sp_at_max_s;
    logic          in_hs_s;
    logic          frame_first_s;
    logic          frame_last_s;

    // Handshake and position decode of the current counter values.
    always_comb begin
        in_ready      = ~out_valid | out_ready;
        in_hs_s       = in_valid & in_ready;
        chan_at_max_s = (chan_cnt_r == CHAN_MAX);
        sp_at_max_s   = (sp_cnt_r == SP_MAX);
        frame_first_s = (chan_cnt_r == {CW{1'b0}}) & (sp_cnt_r == {SW{1'b0}});
        frame_last_s  = chan_at_max_s & sp_at_max_s;
    end

    // Next frame position: the inner dimension steps every beat, the outer
    // one steps when the inner wraps, and both wrap together at frame end.
    always_comb begin
        chan_nxt_s = chan_cnt_r;
        sp_nxt_s   = sp_cnt_r;
        if (ORDER == 0) begin
            if (sp_at_max_s) begin
                sp_nxt_s = {SW{1'b0}};
                if (chan_at_max_s) begin
                    chan_nxt_s = {CW{1'b0}};
                end else begin
                    chan_nxt_s = chan_cnt_r + CW'(1);
                end
            end else begin
                sp_nxt_s = sp_cnt_r + SW'(1);
            end
        end else begin
            if (chan_at_max_s) begin
                chan_nxt_s = {CW{1'b0}};
                if (sp_at_max_s) begin
                    sp_nxt_s = {SW{1'b0}};
                end else begin
                    sp_nxt_s = sp_cnt_r + SW'(1);
                end
            end else begin
                chan_nxt_s = chan_cnt_r + CW'(1);
            end
        end
    end

    // Position counters: clear restarts the frame even when a beat is taken
    // in the same cycle (that beat still carries the pre-clear position).
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_cnt_r <= {CW{1'b0}};
            sp_cnt_r   <= {SW{1'b0}};
        end else if (clear) begin
            chan_cnt_r <= {CW{1'b0}};
            sp_cnt_r   <= {SW{1'b0}};
        end else if (in_hs_s) begin
            chan_cnt_r <= chan_nxt_s;
            sp_cnt_r   <= sp_nxt_s;
        end else begin
            chan_cnt_r <= chan_cnt_r;
            sp_cnt_r   <= sp_cnt_r;
        end
    end

    // Output register stage; clear deliberately has no effect here so a
    // beat already held keeps its tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_data        <= {DATA_WIDTH{1'b0}};
            out_channel     <= {CW{1'b0}};
            out_spatial     <= {SW{1'b0}};
            out_group       <= {GW{1'b0}};
            out_frame_first <= 1'b0;
            out_frame_last  <= 1'b0;
        end else if (in_hs_s) begin
            out_valid       <= 1'b1;
            out_data        <= in_data;
            out_channel     <= chan_cnt_r;
            out_spatial     <= sp_cnt_r;
            out_group       <= group_of(chan_cnt_r);
            out_frame_first <= frame_first_s;
            out_frame_last  <= frame_last_s;
        end else if (out_ready) begin
            out_valid       <= 1'b0;
        end else begin
            out_valid       <= out_valid;
        end
    end

`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
    // Completed-frame counter; clear wins over a frame-last beat taken in the
    // same cycle because clear restarts frame bookkeeping as a whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= 16'd0;
        end else if (clear) begin
            frame_count <= 16'd0;
        end else if (in_hs_s && frame_last_s) begin
            frame_count <= frame_count + 16'd1;
        end else begin
            frame_count <= frame_count;
        end
    end
`endif

endmodule

// File: tb/tb_channel_spatial_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for channel_spatial_sequencer. Three instances (2x3 spatial-inner,
// 4x2 channel-inner with 2 groups, 1x1) share one stimulus stream, so they
// accept exactly the same beats. The reference model counts accepted beats
// since the last restart and derives each beat's tags from that index with
// plain arithmetic; a queue holds the beat expected on the output register.
// -----------------------------------------------------------------------------
module tb_channel_spatial_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'd0;

    logic        a_in_ready, a_valid, a_ff, a_fl;
    logic [31:0] a_data;
    logic        a_chan;
    logic [1:0]  a_sp;
    logic        a_grp;
    logic [15:0] a_fc;

    logic        b_in_ready, b_valid, b_ff, b_fl;
    logic [31:0] b_data;
    logic [1:0]  b_chan;
    logic        b_sp;
    logic        b_grp;
    logic [15:0] b_fc;

    logic        c_in_ready, c_valid, c_ff, c_fl;
    logic [31:0] c_data;
    logic        c_chan;
    logic        c_sp;
    logic        c_grp;
    logic [15:0] c_fc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    channel_spatial_sequencer #(.NUM_CHANNELS(2), .NUM_SPATIAL_BLOCKS(3), .NUM_GROUPS(1),
                                .ORDER(0), .DATA_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
        .out_channel(a_chan), .out_spatial(a_sp), .out_group(a_grp),
        .out_frame_first(a_ff), .out_frame_last(a_fl)
`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
        , .frame_count(a_fc)
`endif
    );

    channel_spatial_sequencer #(.NUM_CHANNELS(4), .NUM_SPATIAL_BLOCKS(2), .NUM_GROUPS(2),
                                .ORDER(1), .DATA_WIDTH(32)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
        .out_channel(b_chan), .out_spatial(b_sp), .out_group(b_grp),
        .out_frame_first(b_ff), .out_frame_last(b_fl)
`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
        , .frame_count(b_fc)
`endif
    );

    channel_spatial_sequencer #(.NUM_CHANNELS(1), .NUM_SPATIAL_BLOCKS(1), .NUM_GROUPS(1),
                                .ORDER(0), .DATA_WIDTH(32)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data),
        .out_channel(c_chan), .out_spatial(c_sp), .out_group(c_grp),
        .out_frame_first(c_ff), .out_frame_last(c_fl)
`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
        , .frame_count(c_fc)
`endif
    );

`ifndef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
    assign a_fc = 16'd0;
    assign b_fc = 16'd0;
    assign c_fc = 16'd0;
`endif

    // Reference model state
    typedef struct {
        logic [31:0] data;
        int          k;
    } beat_t;
    beat_t q[$];
    int    k_idx = 0;               // beats accepted since reset/clear
    int    fc_exp[3] = '{0, 0, 0};
    bit    after_reset = 1'b0;
    int    cfg_nc[3]    = '{2, 4, 1};
    int    cfg_nsb[3]   = '{3, 2, 1};
    int    cfg_ng[3]    = '{1, 2, 1};
    int    cfg_order[3] = '{0, 1, 0};

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Position of beat number k inside its frame for instance i.
    function automatic void beat_tags(input int i, input int k,
                                      output int c, output int s, output int g,
                                      output int ff, output int fl);
        int p;
        p = k % (cfg_nc[i] * cfg_nsb[i]);
        if (cfg_order[i] == 0) begin
            c = p / cfg_nsb[i];
            s = p % cfg_nsb[i];
        end else begin
            c = p % cfg_nc[i];
            s = p / cfg_nc[i];
        end
        g  = c / (cfg_nc[i] / cfg_ng[i]);
        ff = (p == 0) ? 1 : 0;
        fl = (p == cfg_nc[i] * cfg_nsb[i] - 1) ? 1 : 0;
    endfunction

    task automatic check_inst(input string nm, input int i, input logic [31:0] rdy_in,
                              input logic [31:0] vld, input logic [31:0] data,
                              input logic [31:0] c, input logic [31:0] s, input logic [31:0] g,
                              input logic [31:0] ff, input logic [31:0] fl,
                              input logic [31:0] fc);
        int ec, es, eg, eff, efl;
        bit exp_valid;
        exp_valid = (q.size() > 0);
        check_value({nm, ".out_valid"}, vld, 32'(exp_valid));
        check_value({nm, ".in_ready"}, rdy_in, 32'(!exp_valid || out_ready));
        if (exp_valid) begin
            beat_tags(i, q[0].k, ec, es, eg, eff, efl);
            check_value({nm, ".out_data"}, data, q[0].data);
            check_value({nm, ".out_channel"}, c, 32'(ec));
            check_value({nm, ".out_spatial"}, s, 32'(es));
            check_value({nm, ".out_group"}, g, 32'(eg));
            check_value({nm, ".frame_first"}, ff, 32'(eff));
            check_value({nm, ".frame_last"}, fl, 32'(efl));
        end else if (after_reset) begin
            check_value({nm, ".rst_data"}, data, 32'd0);
            check_value({nm, ".rst_tags"}, c | s | g | ff | fl, 32'd0);
        end
`ifdef CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN
        check_value({nm, ".frame_count"}, fc, 32'(fc_exp[i]));
`else
        if (fc !== 32'd0) check_value({nm, ".frame_count_tie"}, fc, 32'd0);
`endif
    endtask

    // One clock cycle: drive at negedge, check just after, update model at posedge.
    task automatic step(input bit v, input bit rdy, input bit clr, input bit rs);
        bit hs, ohs;
        int ec, es, eg, eff, efl;
        in_valid  = v;
        out_ready = rdy;
        clear     = clr;
        rst       = rs;
        in_data   = $urandom;
        #1;
        check_inst("a", 0, 32'(a_in_ready), 32'(a_valid), a_data, 32'(a_chan), 32'(a_sp),
                   32'(a_grp), 32'(a_ff), 32'(a_fl), 32'(a_fc));
        check_inst("b", 1, 32'(b_in_ready), 32'(b_valid), b_data, 32'(b_chan), 32'(b_sp),
                   32'(b_grp), 32'(b_ff), 32'(b_fl), 32'(b_fc));
        check_inst("c", 2, 32'(c_in_ready), 32'(c_valid), c_data, 32'(c_chan), 32'(c_sp),
                   32'(c_grp), 32'(c_ff), 32'(c_fl), 32'(c_fc));
        ohs = (q.size() > 0) && rdy;
        hs  = v && ((q.size() == 0) || rdy);
        @(posedge clk);
        if (rs) begin
            q.delete();
            k_idx = 0;
            for (int i = 0; i < 3; i++) fc_exp[i] = 0;
            after_reset = 1'b1;
        end else begin
            after_reset = 1'b0;
            if (ohs) void'(q.pop_front());
            if (hs) begin
                beat_t b;
                b.data = in_data;
                b.k    = k_idx;
                q.push_back(b);
                for (int i = 0; i < 3; i++) begin
                    beat_tags(i, k_idx, ec, es, eg, eff, efl);
                    if (efl == 1) fc_exp[i] = (fc_exp[i] + 1) & 32'hFFFF;
                end
            end
            if (clr) begin
                k_idx = 0;
                for (int i = 0; i < 3; i++) fc_exp[i] = 0;
            end else if (hs) begin
                k_idx = k_idx + 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Bring all instances out of their unknown power-up state.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        after_reset = 1'b1;
        q.delete();
        k_idx = 0;

        // Continuous flow: one beat per cycle, two full frames of dut_a.
        for (int n = 0; n < 14; n++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Stall three cycles with a beat held, then release.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Clear coincident with the beat at position (1,1) of dut_a.
        for (int n = 0; n < 6 && (k_idx % 6) != 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Clear with no handshake while a beat is held.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-frame on the fourth beat, then stream again.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) step(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional clear and reset.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 23) == 0, ($urandom % 151) == 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/channel_spatial_sequencer.md
CHANNEL_SPATIAL_SEQUENCER -- requirements
Module: channel_spatial_sequencer

Interface
REQ-001 NUM_CHANNELS, default 4: channels per frame, >=1.
REQ-002 NUM_SPATIAL_BLOCKS, default 4: spatial blocks per channel (depth_dim0*depth_dim1), >=1.
REQ-003 NUM_GROUPS, default 2: channel groups, >=1, SHALL divide NUM_CHANNELS; CPG = NUM_CHANNELS/NUM_GROUPS.
REQ-004 ORDER, default 0: 0 = spatial-inner (channel advances after all spatial blocks), 1 = channel-inner.
REQ-005 DATA_WIDTH, default 32: pass-through payload width.
REQ-006 Widths: CW/SW/GW = clog2 of NUM_CHANNELS/NUM_SPATIAL_BLOCKS/NUM_GROUPS, minimum 1.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 clear  in  1  synchronous restart of frame position, pipeline contents kept.
REQ-010 in_valid/in_ready  in/out  1  input beat handshake.
REQ-011 in_data  in  DATA_WIDTH  payload.
REQ-012 out_valid/out_ready  out/in  1  output beat handshake.
REQ-013 out_data  out  DATA_WIDTH  registered payload.
REQ-014 out_channel  out  CW; out_spatial  out  SW; out_group  out  GW: position tags of out_data.
REQ-015 out_frame_first, out_frame_last  out  1  beat is first/last of frame.

Function
REQ-016 Single register stage, latency 1: beat accepted at edge N (in_valid&in_ready) SHALL appear on out_* after edge N.
REQ-017 in_ready SHALL equal !out_valid | out_ready (combinational, full throughput, no bubble under continuous flow).
REQ-018 out_* SHALL hold stable while out_valid & !out_ready.
REQ-019 Position counters (chan_cnt, sp_cnt) SHALL advance only on input handshake; tags for a beat are counter values before advance.
REQ-020 ORDER=0: sp_cnt increments; at NUM_SPATIAL_BLOCKS-1 wraps to 0 and chan_cnt increments; at both maxima both wrap to 0.
REQ-021 ORDER=1: chan_cnt increments; at NUM_CHANNELS-1 wraps to 0 and sp_cnt increments; at both maxima both wrap to 0.
REQ-022 out_group SHALL equal channel tag / CPG (integer division).
REQ-023 out_frame_first = (chan tag==0 & sp tag==0); out_frame_last = (chan tag==NUM_CHANNELS-1 & sp tag==NUM_SPATIAL_BLOCKS-1).
REQ-024 NUM_CHANNELS==1: channel tag constant 0; NUM_SPATIAL_BLOCKS==1: spatial tag constant 0; both 1: every beat first and last.
REQ-025 clear without handshake: counters -> 0 next edge.
REQ-026 clear with handshake same cycle: accepted beat tagged with pre-clear counters; counters -> 0 (not advanced).
REQ-027 clear SHALL NOT alter out_valid or held out_* contents.

Reset
REQ-028 rst SHALL set chan_cnt=0, sp_cnt=0, out_valid=0, out_channel/out_spatial/out_group=0, out_frame_first/out_frame_last=0, out_data=0; rst dominates clear and handshake.
REQ-029 rst mid-frame SHALL drop the registered beat; the next accepted beat is tagged (0,0).

Configuration
REQ-030 Macro CHANNEL_SPATIAL_SEQUENCER_FRAME_COUNT_EN: when defined, output frame_count (16 bits) SHALL exist, reset to 0, increment (wrapping 0xFFFF->0) on each accepted frame-last beat, cleared by clear; when undefined, port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-031 NC=2, NSB=3, ORDER=0, continuous valid, ready=1: tags (c,s) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(0,0); frame_last on 6th beat; one beat per cycle.
REQ-032 NC=4, NSB=2, NG=2, ORDER=1: tags (0,0),(1,0),(2,0),(3,0),(0,1)...; out_group 0,0,1,1 repeating.
REQ-033 out_ready=0 for 3 cycles with out_valid=1: out_* unchanged, in_ready=0, no counter advance; release -> next beat resumes sequence with no loss or duplicate.
REQ-034 clear asserted with handshake on beat (1,1) of NC=2,NSB=3: that beat tagged (1,1), next beat tagged (0,0) frame_first.
REQ-035 rst on 4th beat then stream: out_valid=0 after reset edge, first new beat tagged (0,0).
REQ-036 FRAME_COUNT_EN defined, NC=NSB=1: 5 beats -> frame_count=5, every beat frame_first=frame_last=1.
